// File: rtl/fp_inv_bin.sv
// Modular inverter over GF(P) using the binary extended Euclidean algorithm.
// state | meaning: IDLE wait for start | RUN one reduction step/cycle | FIN done pulse, result valid
module fp_inv_bin #(
   parameter int               WIDTH   = 256,
   parameter logic [WIDTH-1:0] P       = WIDTH'(256'hB640000002A3A6F1D603AB4FF58EC74521F2934B1A7AEEDBE56F9B27E351457D),
   parameter int               MAX_CYC = 4*WIDTH+4
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] inv_out
);

   localparam int CW = $clog2(MAX_CYC + 1) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, inv_q, inv_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d, done_q, done_d;
   logic [WIDTH-1:0] a_r;
   logic             u_zero, u_one, v_one, wd_hit;

   // x/2 mod P; the odd case adds P in WIDTH+1 bits so the carry survives the shift
   function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
      logic [WIDTH:0] s;
      s = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
      return s[WIDTH:1];
   endfunction

   function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return (a >= b) ? (a - b) : (a - b + P);
   endfunction

   assign a_r    = (a_in >= P) ? (a_in - P) : a_in;
   assign u_zero = (u_q == '0);
   assign u_one  = (u_q == WIDTH'(1));
   assign v_one  = (v_q == WIDTH'(1));
   assign wd_hit = (cnt_q == CW'(MAX_CYC));

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= S_IDLE;
         u_q     <= '0;
         v_q     <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         inv_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         u_q     <= u_d;
         v_q     <= v_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         inv_q   <= inv_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (u_zero || u_one || v_one || wd_hit) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Result and done are loaded on the RUN->FIN edge so they are valid during FIN
   always_comb begin
      u_d    = u_q;
      v_d    = v_q;
      x1_d   = x1_q;
      x2_d   = x2_q;
      inv_d  = inv_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               u_d   = a_r;
               v_d   = P;
               x1_d  = WIDTH'(1);
               x2_d  = '0;
               cnt_d = '0;
               err_d = 1'b0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (u_zero) begin
               err_d  = 1'b1;
               inv_d  = '0;
               done_d = 1'b1;
            end else if (u_one || v_one) begin
               inv_d  = u_one ? x1_q : x2_q;
               done_d = 1'b1;
            end else if (wd_hit) begin
               err_d  = 1'b1;
               inv_d  = '0;
               done_d = 1'b1;
            end else if (!u_q[0]) begin
               u_d  = u_q >> 1;
               x1_d = half_mod(x1_q);
            end else if (!v_q[0]) begin
               v_d  = v_q >> 1;
               x2_d = half_mod(x2_q);
            end else if (u_q >= v_q) begin
               u_d  = u_q - v_q;
               x1_d = sub_mod(x1_q, x2_q);
            end else begin
               v_d  = v_q - u_q;
               x2_d = sub_mod(x2_q, x1_q);
            end
         end
         default: ;
      endcase
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign err     = err_q;
   assign inv_out = inv_q;

endmodule
